// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream bundle for fifo_stream_reader.
// master = the reader itself, slave = the FIFO and sink around it.
interface fifo_stream_reader_if #(
  parameter int W = 3
);
  logic         fifo_empty;
  logic         fifo_ren;
  logic [W-1:0] fifo_dout;
  logic         flush;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;

  modport master (
    input  fifo_empty, fifo_dout, flush, m_ready,
    output fifo_ren, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, m_ready,
    input  fifo_ren, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a framed valid/ready stream through a 3-entry skid buffer.
// Define READER_STATS_EN to add the beat_cnt/stall_cnt statistics outputs.
module fifo_stream_reader #(
  parameter int W         = 3,
  parameter int FRAME_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus
`ifdef READER_STATS_EN
  ,
  output logic [15:0]          beat_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

  logic [1:0]   occ_reg, occ_next;
  logic [1:0]   rd_ptr_reg, wr_ptr_reg;
  logic         inflight_reg;
  logic [15:0]  frame_cnt_reg;
  logic [W-1:0] buf_word [3];
  logic [2:0]   pending;
  logic         capture;
  logic         pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words buffered plus the one in flight must never exceed the three slots.
  assign pending      = 3'(occ_reg) + 3'(inflight_reg);
  assign bus.fifo_ren = ~bus.fifo_empty & ~bus.flush & rst_n & (pending < 3'd3);

  assign bus.m_valid = (occ_reg != 2'd0);
  assign bus.m_data  = bus.m_valid ? buf_word[rd_ptr_reg] : '0;
  assign bus.m_last  = bus.m_valid & (frame_cnt_reg == LAST_CNT);

  assign pop     = bus.m_valid & bus.m_ready;
  assign capture = inflight_reg & ~bus.flush;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_buf
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (capture && (wr_ptr_reg == 2'(gi))) begin
          entry_reg <= bus.fifo_dout;
        end
      end
      assign buf_word[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    occ_next = occ_reg;
    case ({capture, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg       <= 2'd0;
      inflight_reg  <= 1'b0;
      rd_ptr_reg    <= 2'd0;
      wr_ptr_reg    <= 2'd0;
      frame_cnt_reg <= 16'd0;
    end else if (bus.flush) begin
      // A sink handshake during flush still happens but does not advance the frame.
      occ_reg       <= 2'd0;
      inflight_reg  <= 1'b0;
      rd_ptr_reg    <= 2'd0;
      wr_ptr_reg    <= 2'd0;
      frame_cnt_reg <= 16'd0;
    end else begin
      occ_reg      <= occ_next;
      inflight_reg <= bus.fifo_ren;
      if (capture) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg    <= ptr_inc(rd_ptr_reg);
        frame_cnt_reg <= (frame_cnt_reg == LAST_CNT) ? 16'd0 : frame_cnt_reg + 16'd1;
      end
    end
  end

`ifdef READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else if (bus.flush) begin
      beat_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (pop) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (bus.m_valid && !bus.m_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed scoreboard bench for fifo_stream_reader with a behavioural registered-read FIFO.
module tb_fifo_stream_reader;
  localparam int W  = 3;
  localparam int FL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.W(W)) bus ();

`ifdef READER_STATS_EN
  logic [15:0] beat_cnt;
  logic [15:0] stall_cnt;
`endif

  fifo_stream_reader #(.W(W), .FRAME_LEN(FL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef READER_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Behavioural FIFO: registered read port, contents dropped on reset.
  logic [W-1:0] fifo_mem [64];
  int           fifo_wr = 0;
  int           fifo_rd = 0;
  assign bus.fifo_empty = (fifo_rd == fifo_wr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd       <= fifo_wr;
      bus.fifo_dout <= '0;
    end else if (bus.fifo_ren && (fifo_rd != fifo_wr)) begin
      bus.fifo_dout <= fifo_mem[fifo_rd % 64];
      fifo_rd       <= fifo_rd + 1;
    end
  end

  int           vectors     = 0;
  int           miscompares = 0;
  int           ren_total   = 0;
  int           hs_total    = 0;
  int           exp_pos     = 0;
  logic [W:0]   exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input bit expect_it);
    fifo_mem[fifo_wr % 64] = d;
    fifo_wr++;
    if (expect_it) begin
      exp_q.push_back({(exp_pos == FL - 1) ? 1'b1 : 1'b0, d});
      exp_pos = (exp_pos + 1) % FL;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic monitor_loop();
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         prev_last  = 1'b0;
    logic [W:0]   e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (bus.fifo_ren) begin
        ren_total++;
        chk("ren_on_empty", bus.fifo_empty, 1'b0);
      end
      if (prev_stall && !bus.flush) begin
        chk("hold_valid", bus.m_valid, 1'b1);
        chk("hold_data_last", {bus.m_last, bus.m_data}, {prev_last, prev_data});
      end
      prev_stall = 1'b0;
      if (bus.m_valid && bus.m_ready) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {bus.m_last, bus.m_data}, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("beat_last_data", {bus.m_last, bus.m_data}, e);
          $display("beat data=%0d last=%0b", bus.m_data, bus.m_last);
        end
      end else if (bus.m_valid && !bus.flush) begin
        prev_stall = 1'b1;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
      end
    end
  endtask

  initial begin
    int r0, h0, lat, n;
    logic [W-1:0] d;
    fork
      monitor_loop();
    join_none

    bus.m_ready = 1'b1;
    bus.flush   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("t1_ren", bus.fifo_ren, 1'b0);
      chk("t1_valid", bus.m_valid, 1'b0);
      chk("t1_data", bus.m_data, 0);
      chk("t1_last", bus.m_last, 1'b0);
      tick();
    end

    // 2: preload 4,3,2,1, latency and back-to-back output
    r0 = ren_total;
    h0 = hs_total;
    push(3'd4, 1'b1); push(3'd3, 1'b1); push(3'd2, 1'b1); push(3'd1, 1'b1);
    #1;
    chk("t2_first_ren", bus.fifo_ren, 1'b1);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (bus.m_valid && lat < 0) lat = i;
      if (i == 6) chk("t2_back_to_back", hs_total - h0, 4);
      tick();
    end
    chk("t2_latency", lat, 2);
    drain("t2_drain", 20);
    chk("t2_ren_count", ren_total - r0, 4);

    // 3: backpressure holds three words, then full-rate release
    bus.m_ready = 1'b0;
    r0 = ren_total;
    push(3'd5, 1'b1); push(3'd6, 1'b1); push(3'd7, 1'b1); push(3'd0, 1'b1);
    push(3'd1, 1'b1); push(3'd2, 1'b1); push(3'd3, 1'b1); push(3'd4, 1'b1);
    repeat (20) tick();
    chk("t3_ren_count", ren_total - r0, 3);
    chk("t3_valid", bus.m_valid, 1'b1);
    chk("t3_data", bus.m_data, 5);
    h0 = hs_total;
    bus.m_ready = 1'b1;
    n = 0;
    while (hs_total < h0 + 8 && n < 40) begin
      tick();
      n++;
    end
    chk("t3_cycles_for_8", n, 8);
    drain("t3_drain", 20);

    // 4: framing with alternating ready
    for (int i = 0; i < 10; i++) begin
      d = 3'(i + 1);
      push(d, 1'b1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      bus.m_ready = (n % 2 == 0);
      tick();
      n++;
    end
    bus.m_ready = 1'b1;
    drain("t4_drain", 5);

    // 5: flush with two buffered and one in flight
    bus.m_ready = 1'b0;
    push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd3, 1'b0);
    n = 0;
    while (!bus.m_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t5_valid_before_flush", bus.m_valid, 1'b1);
    tick();
    bus.flush = 1'b1;
    #1;
    chk("t5_ren_in_flush", bus.fifo_ren, 1'b0);
    tick();
    bus.flush = 1'b0;
    chk("t5_valid_after_flush", bus.m_valid, 1'b0);
    chk("t5_data_after_flush", bus.m_data, 0);
`ifdef READER_STATS_EN
    chk("t5_beat_cnt_clr", beat_cnt, 0);
    chk("t5_stall_cnt_clr", stall_cnt, 0);
`endif
    exp_pos = 0;
    push(3'd7, 1'b1); push(3'd5, 1'b1); push(3'd6, 1'b1); push(3'd4, 1'b1);
    bus.m_ready = 1'b1;
    drain("t5_drain", 20);
`ifdef READER_STATS_EN
    chk("t5_beat_cnt", beat_cnt, 4);
`endif

    // 6: asynchronous reset mid-stream
    h0 = hs_total;
    for (int i = 0; i < 8; i++) begin
      d = 3'(i + 1);
      push(d, 1'b1);
    end
    n = 0;
    while (hs_total < h0 + 3 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_streaming", bus.m_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.m_valid, 1'b0);
    chk("t6_rst_data", bus.m_data, 0);
    chk("t6_rst_last", bus.m_last, 1'b0);
    chk("t6_rst_ren", bus.fifo_ren, 1'b0);
    exp_q.delete();
    exp_pos = 0;
    tick();
    tick();
    rst_n = 1'b1;
    push(3'd3, 1'b1); push(3'd1, 1'b1); push(3'd4, 1'b1); push(3'd6, 1'b1);
    drain("t6_drain", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
